// File: rtl/debouncer_pkg.sv
// Debounce constants shared with other board blocks, plus the counter width helper.
package debouncer_pkg;

  localparam int DEB_STABLE_CYCLES = 8;
  localparam int DEB_SYNC_STAGES   = 2;

  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for asynchronous inputs; latency STAGES edges.
// Only the first stage may go metastable; the rest give it time to resolve.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Synchronizes and debounces a push-button, pulsing press for one cycle per clean press.
// Latency SYNC_STAGES-1+STABLE_CYCLES edges from first sample; no backpressure, releases are silent.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEB_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int            CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          btn_s;
  logic          state;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          settle;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (btn_s)
  );

  assign differ = (btn_s != state);
  assign settle = differ && (cnt == CNT_LAST);

  // Counter clears on any return to the debounced level, so bounce never accumulates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= settle && btn_s;
      if (!differ) begin
        cnt <= '0;
      end else if (settle) begin
        state <= btn_s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer: sliding-window reference model plus hand-computed pulse counts and edges.
module tb_debouncer;

  localparam int STABLE = 8;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC - 1 + STABLE;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic press;

  debouncer #(
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  always #5 clk = ~clk;

  int nchk   = 0;
  int npass  = 0;
  int ecnt   = 0;
  int npulse = 0;

  always @(posedge clk) ecnt++;
  always @(negedge clk) if (press === 1'b1) npulse++;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference: state flips once the last STABLE synchronized samples, all taken
  // since the previous flip, disagree with it.
  bit samp [0:8191];
  bit bs   [0:8191];
  int m_edge  = 0;
  int m_flip  = 0;
  bit m_state = 1'b0;
  bit m_press = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edge  = 0;
      m_flip  = 0;
      m_state = 1'b0;
      m_press = 1'b0;
    end else begin
      bit ok;
      m_edge++;
      bs[m_edge]   = (m_edge - SYNC >= 1) ? samp[m_edge - SYNC] : 1'b0;
      samp[m_edge] = btn;
      ok = (m_edge - (STABLE - 1) >= m_flip + 1);
      for (int i = 0; i < STABLE; i++)
        if (ok && bs[m_edge - i] == m_state) ok = 1'b0;
      if (ok) begin
        m_state = ~m_state;
        m_flip  = m_edge;
        m_press = m_state;
      end else begin
        m_press = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("press_vs_model", int'(press), int'(m_press));
      chk("state_vs_model", int'(dut.state), int'(m_state));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // sel=0: wait for press high; sel=1: wait for debounced state low.
  task automatic wait_evt(input bit sel, input int exp_edge, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (sel ? (dut.state === 1'b0) : (press === 1'b1)) begin
        seen = 1'b1;
        chk(name, ecnt, exp_edge);
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int  k;
    int  p0;
    bit  seen;

    rst = 1'b1;
    btn = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #3 btn = ~btn;
      chk("rst_press", int'(press), 0);
      chk("rst_state", int'(dut.state), 0);
      chk("rst_cnt", int'(dut.cnt), 0);
      chk("rst_btn_s", int'(dut.btn_s), 0);
    end
    #2;
    btn = 1'b0;
    rst = 1'b1;

    // Clean press then release.
    idle(5);
    @(negedge clk);
    btn = 1'b1;
    k   = ecnt + 1;
    p0  = npulse;
    wait_evt(1'b0, k + LAT, "clean_press_edge");
    idle(15);
    chk("clean_press_count", npulse - p0, 1);
    @(negedge clk);
    btn = 1'b0;
    k   = ecnt + 1;
    wait_evt(1'b1, k + LAT, "release_edge");
    idle(10);
    chk("release_no_pulse", npulse - p0, 1);

    // Glitch shorter than one clock.
    @(negedge clk);
    p0 = npulse;
    #2 btn = 1'b1;
    #5 btn = 1'b0;
    idle(20);
    chk("glitch_no_press", npulse - p0, 0);

    // Five 1-unit bounces ending high.
    @(posedge clk);
    #1;
    k  = ecnt + 1;
    p0 = npulse;
    repeat (5) begin
      btn = ~btn;
      #1;
    end
    wait_evt(1'b0, k + LAT, "bounce_press_edge");
    idle(15);
    chk("bounce_press_count", npulse - p0, 1);
    btn = 1'b0;
    idle(20);

    // Seven stable samples: below threshold.
    @(negedge clk);
    btn = 1'b1;
    p0  = npulse;
    repeat (7) @(negedge clk);
    btn = 1'b0;
    idle(20);
    chk("subthresh7_no_press", npulse - p0, 0);

    // Eight stable samples: exactly enough.
    @(negedge clk);
    btn = 1'b1;
    k   = ecnt + 1;
    p0  = npulse;
    repeat (8) @(negedge clk);
    btn = 1'b0;
    wait_evt(1'b0, k + LAT, "thresh8_press_edge");
    idle(20);
    chk("thresh8_count", npulse - p0, 1);

    // Press, long release, re-press; then a short release in between.
    p0 = npulse;
    @(negedge clk);
    btn = 1'b1;
    idle(20);
    btn = 1'b0;
    idle(20);
    btn = 1'b1;
    idle(20);
    chk("repress_two_pulses", npulse - p0, 2);
    btn = 1'b0;
    idle(5);
    btn = 1'b1;
    idle(20);
    chk("short_release_no_extra", npulse - p0, 2);
    btn = 1'b0;
    idle(20);

    // Async reset while press is high, with btn held through reset.
    @(negedge clk);
    btn  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (press === 1'b1) seen = 1'b1;
    end
    chk("midpulse_seen", int'(seen), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_press_low", int'(press), 0);
    chk("async_rst_state_low", int'(dut.state), 0);
    idle(3);
    chk("held_rst_press_low", int'(press), 0);
    @(negedge clk);
    rst = 1'b1;
    k   = ecnt + 1;
    p0  = npulse;
    wait_evt(1'b0, k + LAT, "post_rst_press_edge");
    idle(15);
    chk("post_rst_count", npulse - p0, 1);
    btn = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
